gp_arbiter: RTL

GP_ARBITER -- requirements
Module: gp_arbiter

---
 rtl/gp_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/gp_arbiter.sv
// gp_arbiter: three-way round-robin arbiter in front of a single graphics
// processor. A granted requester's rectangle command is latched and
// presented on gp_* with gp_en. It is held until the processor raises
// gp_finish, or until the optional watchdog aborts it. The processor's
// finish level must then fall before the next command can be issued.
module gp_arbiter #(
    parameter int unsigned TIMEOUT = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [2:0]  req_opcode,
    input  logic [29:0] req_tl_x,
    input  logic [26:0] req_tl_y,
    input  logic [29:0] req_br_x,
    input  logic [26:0] req_br_y,
    input  logic [35:0] req_arg,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        timeout_err,
    output logic        gp_en,
    output logic        gp_opcode,
    output logic [9:0]  gp_tl_x,
    output logic [8:0]  gp_tl_y,
    output logic [9:0]  gp_br_x,
    output logic [8:0]  gp_br_y,
    output logic [11:0] gp_arg,
    input  logic        gp_finish
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // Watchdog threshold: a zero TIMEOUT switches the abort path off.
    localparam logic [31:0] TIMEOUT_W = TIMEOUT;
    localparam logic        WDOG_ON   = (TIMEOUT_W != 32'd0);
    localparam logic [31:0] WDOG_LAST = WDOG_ON ? (TIMEOUT_W - 32'd1) : 32'd0;

    // One-hot encoding of a requester index (0..2).
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] res;
        case (idx)
            2'd0:    res = 3'b001;
            2'd1:    res = 3'b010;
            2'd2:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Successor of a requester index, modulo 3.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] res;
        case (idx)
            2'd0:    res = 2'd1;
            2'd1:    res = 2'd2;
            2'd2:    res = 2'd0;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Round-robin search starting at ptr_v; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] req_v,
                                           input logic [1:0] ptr_v);
        logic [2:0] res;
        logic [1:0] cand;
        res  = 3'b000;
        cand = (ptr_v == 2'd3) ? 2'd0 : ptr_v;
        for (int k = 0; k < 3; k++) begin
            if (!res[2] && req_v[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
            cand = next_idx(cand);
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [1:0]  ptr_r;
    logic [1:0]  owner_r;
    logic [31:0] wdog_r;

    logic [2:0]  pick_s;
    logic        pick_found_s;
    logic [1:0]  pick_idx_s;

    logic        launch_s;
    logic        finish_exit_s;
    logic        wdog_exit_s;
    logic        exit_s;
    logic        leave_s;
    logic        wdog_expired_s;

    logic        sel_opcode_s;
    logic [9:0]  sel_tl_x_s;
    logic [8:0]  sel_tl_y_s;
    logic [9:0]  sel_br_x_s;
    logic [8:0]  sel_br_y_s;
    logic [11:0] sel_arg_s;

    logic [2:0]  grant_r;
    logic [2:0]  done_r;
    logic        timeout_err_r;
    logic        gp_en_r;
    logic        gp_opcode_r;
    logic [9:0]  gp_tl_x_r;
    logic [8:0]  gp_tl_y_r;
    logic [9:0]  gp_br_x_r;
    logic [8:0]  gp_br_y_r;
    logic [11:0] gp_arg_r;

    // Round-robin winner among the live requests.
    always_comb begin
        pick_s       = rr_pick(req, ptr_r);
        pick_found_s = pick_s[2];
        pick_idx_s   = pick_s[1:0];
    end

    // Command fields of the current winner, extracted from the packed buses.
    always_comb begin
        sel_opcode_s = 1'b0;
        sel_tl_x_s   = 10'd0;
        sel_tl_y_s   = 9'd0;
        sel_br_x_s   = 10'd0;
        sel_br_y_s   = 9'd0;
        sel_arg_s    = 12'd0;
        case (pick_idx_s)
            2'd0: begin
                sel_opcode_s = req_opcode[0];
                sel_tl_x_s   = req_tl_x[9:0];
                sel_tl_y_s   = req_tl_y[8:0];
                sel_br_x_s   = req_br_x[9:0];
                sel_br_y_s   = req_br_y[8:0];
                sel_arg_s    = req_arg[11:0];
            end
            2'd1: begin
                sel_opcode_s = req_opcode[1];
                sel_tl_x_s   = req_tl_x[19:10];
                sel_tl_y_s   = req_tl_y[17:9];
                sel_br_x_s   = req_br_x[19:10];
                sel_br_y_s   = req_br_y[17:9];
                sel_arg_s    = req_arg[23:12];
            end
            2'd2: begin
                sel_opcode_s = req_opcode[2];
                sel_tl_x_s   = req_tl_x[29:20];
                sel_tl_y_s   = req_tl_y[26:18];
                sel_br_x_s   = req_br_x[29:20];
                sel_br_y_s   = req_br_y[26:18];
                sel_arg_s    = req_arg[35:24];
            end
            default: begin
                sel_opcode_s = 1'b0;
                sel_tl_x_s   = 10'd0;
                sel_tl_y_s   = 9'd0;
                sel_br_x_s   = 10'd0;
                sel_br_y_s   = 9'd0;
                sel_arg_s    = 12'd0;
            end
        endcase
    end

    // Watchdog fires on the last permitted BUSY cycle.
    always_comb begin
        wdog_expired_s = WDOG_ON & (wdog_r == WDOG_LAST);
    end

    // Next-state logic and the single-cycle control strobes it produces.
    always_comb begin
        state_nx_s    = state_r;
        launch_s      = 1'b0;
        finish_exit_s = 1'b0;
        wdog_exit_s   = 1'b0;
        leave_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A finish level still high from the last command blocks issue.
                if (!gp_finish && pick_found_s) begin
                    launch_s   = 1'b1;
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A real finish takes priority over a simultaneous watchdog hit.
                if (gp_finish) begin
                    finish_exit_s = 1'b1;
                    state_nx_s    = ST_RELEASE;
                end else if (wdog_expired_s) begin
                    wdog_exit_s = 1'b1;
                    state_nx_s  = ST_RELEASE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                if (!gp_finish) begin
                    leave_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign exit_s = finish_exit_s | wdog_exit_s;

    // State, fairness pointer, current owner and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            owner_r <= 2'd0;
            wdog_r  <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            if (exit_s) begin
                ptr_r <= next_idx(owner_r);
            end else begin
                ptr_r <= ptr_r;
            end
            if (launch_s) begin
                owner_r <= pick_idx_s;
            end else begin
                owner_r <= owner_r;
            end
            if (launch_s) begin
                wdog_r <= 32'd0;
            end else if (state_r == ST_BUSY) begin
                wdog_r <= wdog_r + 32'd1;
            end else begin
                wdog_r <= wdog_r;
            end
        end
    end

    // Grant, command-valid and the one-cycle completion/abort pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r       <= 3'b000;
            done_r        <= 3'b000;
            timeout_err_r <= 1'b0;
            gp_en_r       <= 1'b0;
        end else begin
            if (launch_s) begin
                grant_r <= onehot3(pick_idx_s);
            end else if (leave_s) begin
                grant_r <= 3'b000;
            end else begin
                grant_r <= grant_r;
            end
            done_r        <= exit_s ? onehot3(owner_r) : 3'b000;
            timeout_err_r <= wdog_exit_s;
            if (launch_s) begin
                gp_en_r <= 1'b1;
            end else if (exit_s) begin
                gp_en_r <= 1'b0;
            end else begin
                gp_en_r <= gp_en_r;
            end
        end
    end

    // Command latch: captured only at launch, so requester changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp_opcode_r <= 1'b0;
            gp_tl_x_r   <= 10'd0;
            gp_tl_y_r   <= 9'd0;
            gp_br_x_r   <= 10'd0;
            gp_br_y_r   <= 9'd0;
            gp_arg_r    <= 12'd0;
        end else if (launch_s) begin
            gp_opcode_r <= sel_opcode_s;
            gp_tl_x_r   <= sel_tl_x_s;
            gp_tl_y_r   <= sel_tl_y_s;
            gp_br_x_r   <= sel_br_x_s;
            gp_br_y_r   <= sel_br_y_s;
            gp_arg_r    <= sel_arg_s;
        end else begin
            gp_opcode_r <= gp_opcode_r;
            gp_tl_x_r   <= gp_tl_x_r;
            gp_tl_y_r   <= gp_tl_y_r;
            gp_br_x_r   <= gp_br_x_r;
            gp_br_y_r   <= gp_br_y_r;
            gp_arg_r    <= gp_arg_r;
        end
    end

    assign grant       = grant_r;
    assign done        = done_r;
    assign timeout_err = timeout_err_r;
    assign gp_en       = gp_en_r;
    assign gp_opcode   = gp_opcode_r;
    assign gp_tl_x     = gp_tl_x_r;
    assign gp_tl_y     = gp_tl_y_r;
    assign gp_br_x     = gp_br_x_r;
    assign gp_br_y     = gp_br_y_r;
    assign gp_arg      = gp_arg_r;

endmodule
